// File: rtl/blast_hit_packer.sv
// blast_hit_packer: filters BLAST extension results, packs survivors as
// 64-bit records eight per 512-bit line, and writes lines to DDR at
// consecutive addresses starting from BASE_ADDR.
module blast_hit_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned MIN_LEN   = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         res_valid,
  input  logic [31:0]  loc_start,
  input  logic [31:0]  loc_end,
  input  logic [10:0]  score,
  output logic         res_ready,
  input  logic         flush,
  output logic         flush_done,
  output logic         ddr_wr,
  output logic [31:0]  ddr_wr_addr,
  output logic [511:0] ddr_wr_data,
  input  logic         ddr_wr_done,
  output logic [15:0]  rec_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} wr_state_t;

  wr_state_t      r_state;
  logic [3:0]     r_pack_cnt;
  logic           r_line_valid;
  logic [511:0]   r_line_data;
  logic           r_flush_pend;
  logic [15:0]    r_rec_count;
  logic           r_dup_valid;
  logic [31:0]    r_dup_start;
  logic [31:0]    r_dup_end;
  logic           r_ddr_wr;
  logic [31:0]    r_addr_ptr;

  logic [32:0]    w_len;
  logic [20:0]    w_len_sat;
  logic [63:0]    w_record;
  logic           w_ready;
  logic           w_accept;
  logic           w_keep;
  logic           w_dup;
  logic           w_move;
  logic           w_flush_done;
  logic [511:0]   w_line_next;

  // Length is computed one bit wider so a full-range extension does not wrap.
  assign w_len     = {1'b0, loc_end} - {1'b0, loc_start} + 33'd1;
  assign w_len_sat = (w_len > 33'h1F_FFFF) ? 21'h1F_FFFF : w_len[20:0];
  assign w_record  = {score, w_len_sat, loc_start};
  assign w_dup     = r_dup_valid && (loc_start == r_dup_start) && (loc_end == r_dup_end);

  assign w_ready  = rst && (r_pack_cnt < 4'd8) && !r_flush_pend;
  assign w_accept = res_valid && w_ready;
  assign w_keep   = w_accept && (loc_end >= loc_start) && (w_len >= 33'(MIN_LEN)) && !w_dup;

  // A full pack, or any partial pack while a flush is pending, moves into a free line.
  assign w_move       = !r_line_valid && ((r_pack_cnt == 4'd8) || (r_flush_pend && (r_pack_cnt != 4'd0)));
  assign w_flush_done = r_flush_pend && (r_pack_cnt == 4'd0) && !r_line_valid && (r_state == ST_IDLE);

  assign res_ready   = w_ready;
  assign flush_done  = w_flush_done;
  assign ddr_wr      = r_ddr_wr;
  assign ddr_wr_addr = r_addr_ptr;
  assign ddr_wr_data = r_line_data;
  assign rec_count   = r_rec_count;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      logic [63:0] r_slot;
      // Capture a kept record when this slot is the next free one.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_slot <= '0;
        end else if (w_keep && (r_pack_cnt == 4'(gi))) begin
          r_slot <= w_record;
        end
      end
      // Slots beyond the fill level read as zero so partial lines are zero-padded.
      assign w_line_next[64*gi +: 64] = (r_pack_cnt > 4'(gi)) ? r_slot : 64'd0;
    end
  endgenerate

  // Pack fill level, record counter and last-kept duplicate register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pack_cnt  <= 4'd0;
      r_rec_count <= 16'd0;
      r_dup_valid <= 1'b0;
      r_dup_start <= 32'd0;
      r_dup_end   <= 32'd0;
    end else begin
      if (w_move) begin
        r_pack_cnt <= 4'd0;
      end else if (w_keep) begin
        r_pack_cnt <= r_pack_cnt + 4'd1;
      end
      if (w_keep) begin
        if (r_rec_count != 16'hFFFF) begin
          r_rec_count <= r_rec_count + 16'd1;
        end
        r_dup_valid <= 1'b1;
        r_dup_start <= loc_start;
        r_dup_end   <= loc_end;
      end
    end
  end

  // Flush request latch; repeated requests while pending are absorbed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flush_pend <= 1'b0;
    end else if (w_flush_done) begin
      r_flush_pend <= 1'b0;
    end else if (flush) begin
      r_flush_pend <= 1'b1;
    end
  end

  // Line register: loaded from the pack, released once DDR confirms the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_line_valid <= 1'b0;
      r_line_data  <= '0;
    end else if (w_move) begin
      r_line_valid <= 1'b1;
      r_line_data  <= w_line_next;
    end else if ((r_state == ST_WAIT) && ddr_wr_done) begin
      r_line_valid <= 1'b0;
    end
  end

  // Write FSM: one-cycle write strobe, then hold until the DDR completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ddr_wr   <= 1'b0;
      r_addr_ptr <= BASE_ADDR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ddr_wr <= 1'b0;
          if (r_line_valid) begin
            r_ddr_wr <= 1'b1;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_ddr_wr <= 1'b0;
          if (ddr_wr_done) begin
            r_addr_ptr <= r_addr_ptr + 32'd64;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_ddr_wr <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blast_hit_packer.sv
// Testbench for blast_hit_packer: table-driven filter vectors, hand-written
// flush/reset sequences and randomized traffic against a record-queue model.
module tb_blast_hit_packer;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          MIN_LEN = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         res_valid = 1'b0;
  logic [31:0]  loc_start = '0;
  logic [31:0]  loc_end = '0;
  logic [10:0]  score = '0;
  logic         res_ready;
  logic         flush = 1'b0;
  logic         flush_done;
  logic         ddr_wr;
  logic [31:0]  ddr_wr_addr;
  logic [511:0] ddr_wr_data;
  logic         ddr_wr_done = 1'b0;
  logic [15:0]  rec_count;

  always #5 clk = ~clk;

  blast_hit_packer #(.BASE_ADDR(BASE), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .loc_start(loc_start),
    .loc_end(loc_end), .score(score), .res_ready(res_ready), .flush(flush),
    .flush_done(flush_done), .ddr_wr(ddr_wr), .ddr_wr_addr(ddr_wr_addr),
    .ddr_wr_data(ddr_wr_data), .ddr_wr_done(ddr_wr_done), .rec_count(rec_count)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [511:0] data;
  } line_t;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [10:0] sc;
    logic [15:0] cnt;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: kept records waiting for a line, and the expected lines.
  logic [63:0] exp_recs[$];
  line_t       exp_lines[$];
  line_t       cap_q[$];
  logic [31:0] exp_addr = BASE;
  logic        last_v = 1'b0;
  logic [31:0] last_s = '0;
  logic [31:0] last_e = '0;
  int          model_count = 0;
  int          max_stall = 0;

  // DDR responder state
  int    ddr_delay = 3;
  bit    resp_busy = 1'b0;
  int    resp_cnt = 0;
  int    cyc = 0;
  int    fd_count = 0;
  int    fd_cyc = -10;
  int    last_done_cyc = -10;
  line_t resp_line;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic emit_line();
    line_t l;
    l.addr = exp_addr;
    l.data = '0;
    foreach (exp_recs[i]) l.data[64*i +: 64] = exp_recs[i];
    exp_lines.push_back(l);
    exp_addr = exp_addr + 32'd64;
    exp_recs.delete();
  endtask

  task automatic model_accept(input logic [31:0] s, input logic [31:0] e, input logic [10:0] sc);
    longint len;
    logic [20:0] l21;
    len = longint'(e) - longint'(s) + 1;
    if (e < s) return;
    if (len < MIN_LEN) return;
    if (last_v && (s == last_s) && (e == last_e)) return;
    last_v = 1'b1;
    last_s = s;
    last_e = e;
    l21 = (len > 64'h1F_FFFF) ? 21'h1F_FFFF : 21'(len);
    exp_recs.push_back({sc, l21, s});
    if (model_count < 65535) model_count++;
    if (exp_recs.size() == 8) emit_line();
  endtask

  task automatic model_flush();
    if (exp_recs.size() > 0) emit_line();
  endtask

  // DDR side: capture each write, check hold, answer after ddr_delay cycles.
  initial begin : responder
    forever begin
      @(negedge clk);
      cyc++;
      if (flush_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      ddr_wr_done = 1'b0;
      if (!rst) begin
        resp_busy = 1'b0;
      end else if (resp_busy) begin
        chk("wr_single_cycle", ddr_wr, 1'b0);
        if (resp_cnt == 0) begin
          chk("hold_addr", ddr_wr_addr, resp_line.addr);
          chk("hold_data", ddr_wr_data, resp_line.data);
          ddr_wr_done = 1'b1;
          resp_busy = 1'b0;
          last_done_cyc = cyc;
        end else begin
          resp_cnt--;
        end
      end else if (ddr_wr) begin
        resp_line.addr = ddr_wr_addr;
        resp_line.data = ddr_wr_data;
        cap_q.push_back(resp_line);
        resp_busy = 1'b1;
        resp_cnt = ddr_delay;
      end
    end
  end

  task automatic send(input logic [31:0] s, input logic [31:0] e, input logic [10:0] sc);
    int t = 0;
    while (!res_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t > max_stall) max_stall = t;
    if (!res_ready) begin
      chk("ready_timeout", res_ready, 1'b1);
      return;
    end
    res_valid = 1'b1;
    loc_start = s;
    loc_end = e;
    score = sc;
    model_accept(s, e, sc);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic send_flush(input logic [31:0] s, input logic [31:0] e, input logic [10:0] sc);
    int t = 0;
    while (!res_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("sf_ready", res_ready, 1'b1);
    res_valid = 1'b1;
    flush = 1'b1;
    loc_start = s;
    loc_end = e;
    score = sc;
    model_accept(s, e, sc);
    model_flush();
    @(negedge clk);
    res_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_fd(input int limit);
    int t = 0;
    while (!flush_done && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("flush_done_seen", flush_done, 1'b1);
  endtask

  task automatic check_lines(input string tag);
    #1;
    chk({tag, "_line_cnt"}, cap_q.size(), exp_lines.size());
    for (int i = 0; i < cap_q.size() && i < exp_lines.size(); i++) begin
      chk($sformatf("%s_addr_%0d", tag, i), cap_q[i].addr, exp_lines[i].addr);
      chk($sformatf("%s_data_%0d", tag, i), cap_q[i].data, exp_lines[i].data);
    end
    cap_q.delete();
    exp_lines.delete();
  endtask

  task automatic drain(input string tag);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    wait_fd(800);
    check_lines(tag);
  endtask

  task automatic reset_task();
    rst = 1'b0;
    res_valid = 1'b0;
    flush = 1'b0;
    exp_recs.delete();
    last_v = 1'b0;
    model_count = 0;
    exp_addr = BASE;
    repeat (2) @(negedge clk);
    chk("rst_ready", res_ready, 1'b0);
    chk("rst_wr", ddr_wr, 1'b0);
    chk("rst_addr", ddr_wr_addr, BASE);
    chk("rst_data", ddr_wr_data, 512'd0);
    chk("rst_count", rec_count, 16'd0);
    chk("rst_fd", flush_done, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", res_ready, 1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[16];
    int fd_before;
    int t;
    logic [31:0] s, e, prev_s, prev_e;
    logic [10:0] sc;
    logic want, f;

    for (int k = 0; k < 8; k++) tbl[k] = '{32'(100*k), 32'(100*k + 19), 11'(k), 16'(k + 1)};
    tbl[8]  = '{32'd500,  32'd400,  11'd1, 16'd8};
    tbl[9]  = '{32'd1000, 32'd1009, 11'd2, 16'd8};
    tbl[10] = '{32'd700,  32'd719,  11'd3, 16'd8};
    tbl[11] = '{32'd2000, 32'd2010, 11'd4, 16'd9};
    tbl[12] = '{32'd3000, 32'd3000, 11'd5, 16'd9};
    tbl[13] = '{32'd2000, 32'd2010, 11'd6, 16'd9};
    tbl[14] = '{32'd0,    32'hFFFF_FFFF, 11'h7FF, 16'd10};
    tbl[15] = '{32'd2000, 32'd2010, 11'd9, 16'd11};

    // Reset and filter table
    reset_task();
    ddr_delay = 3;
    for (int i = 0; i < 16; i++) begin
      send(tbl[i].s, tbl[i].e, tbl[i].sc);
      chk($sformatf("tbl_count_%0d", i), rec_count, tbl[i].cnt);
      $display("vec %0d: start=%0d end=%0d score=%0d rec_count=%0d", i, tbl[i].s, tbl[i].e, tbl[i].sc, rec_count);
      if (i == 7) begin
        chk("full_ready_low", res_ready, 1'b0);
        chk("full_wr_low", ddr_wr, 1'b0);
        @(negedge clk);
        chk("move_ready_back", res_ready, 1'b1);
        chk("wr_not_early", ddr_wr, 1'b0);
        @(negedge clk);
        chk("wr_pulse", ddr_wr, 1'b1);
        chk("wr_addr_base", ddr_wr_addr, BASE);
        #1;
        chk("line0_captured", cap_q.size(), 1);
        if (cap_q.size() > 0) chk("line0_slot0", cap_q[0].data[63:0], {11'd0, 21'd20, 32'd0});
      end
    end

    // Partial-line flush, then an empty flush
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    chk("pend_ready_low", res_ready, 1'b0);
    wait_fd(300);
    #1;
    chk("fd_after_done", fd_cyc, last_done_cyc + 1);
    $display("flush: partial line done at cycle %0d", fd_cyc);
    check_lines("flush3");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("empty_flush_done", flush_done, 1'b1);
    @(negedge clk);
    chk("empty_flush_pulse", flush_done, 1'b0);
    check_lines("empty_flush");
    $display("flush: empty flush complete");

    // Back-pressure with slow DDR
    reset_task();
    ddr_delay = 30;
    max_stall = 0;
    for (int k = 0; k < 20; k++) send(32'h0010_0000 + 32'(k*64), 32'h0010_0000 + 32'(k*64 + 30 + k), 11'(k + 20));
    drain("stall");
    chk("stall_seen", max_stall >= 10, 1'b1);
    chk("stall_count", rec_count, 16'd20);
    $display("stall: 20 records, max ready stall %0d cycles", max_stall);

    // Accept in the same cycle as flush, plus an absorbed second flush
    ddr_delay = 5;
    @(negedge clk);
    #1;
    fd_before = fd_count;
    send(32'd40000, 32'd40050, 11'd1);
    send(32'd41000, 32'd41100, 11'd2);
    send_flush(32'd42000, 32'd42011, 11'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_fd(300);
    repeat (12) @(negedge clk);
    #1;
    chk("single_flush_done", fd_count - fd_before, 1);
    check_lines("same_cycle");
    $display("same-cycle flush: flush_done pulses %0d", fd_count - fd_before);

    // Reset while a write is outstanding
    ddr_delay = 30;
    for (int k = 0; k < 8; k++) send(32'd50000 + 32'(k*100), 32'd50000 + 32'(k*100 + 40), 11'(k));
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      #1;
      if (resp_busy) break;
      t++;
    end
    chk("mid_write_busy", resp_busy, 1'b1);
    check_lines("pre_reset");
    reset_task();
    for (int k = 0; k < 8; k++) send(32'd50000 + 32'(k*100), 32'd50000 + 32'(k*100 + 40), 11'(k));
    drain("post_reset");
    chk("post_reset_count", rec_count, 16'd8);
    $display("reset mid-write: rec_count=%0d", rec_count);

    // Randomized traffic against the model
    prev_s = 32'd0;
    prev_e = 32'd20;
    for (int r = 0; r < 3; r++) begin
      ddr_delay = (r == 0) ? 0 : ((r == 1) ? int'($urandom_range(1, 6)) : 12);
      for (int i = 0; i < 300; i++) begin
        chk("rand_count", rec_count, 16'(model_count));
        want = ($urandom_range(0, 3) != 0);
        f = (i < 260) && ($urandom_range(0, 15) == 0);
        s = 32'($urandom_range(0, 40)) * 32'd16;
        case ($urandom_range(0, 5))
          0: e = s - 32'($urandom_range(1, 5));
          1: e = s + 32'(MIN_LEN - 2);
          2: e = s + 32'(MIN_LEN - 1);
          3: e = s + 32'($urandom_range(MIN_LEN, 3000));
          4: begin s = prev_s; e = prev_e; end
          default: e = s + 32'($urandom());
        endcase
        sc = 11'($urandom_range(0, 2047));
        prev_s = s;
        prev_e = e;
        res_valid = want;
        loc_start = s;
        loc_end = e;
        score = sc;
        flush = f;
        if (want && res_ready) model_accept(s, e, sc);
        if (f) model_flush();
        @(negedge clk);
      end
      res_valid = 1'b0;
      flush = 1'b0;
      repeat (80) @(negedge clk);
      drain($sformatf("rand%0d", r));
      chk("rand_final_count", rec_count, 16'(model_count));
      $display("random round %0d: delay %0d, rec_count=%0d", r, ddr_delay, rec_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/blast_hit_packer.md
# blast_hit_packer

Downstream result stage of the BLAST seed-and-extend pipeline. Accepts extension results (start/end location and score) from the expand/memory-interface stage and filters out invalid, short and back-to-back duplicate results. Packs survivors as 64-bit records, eight per 512-bit line, and writes each line to DDR at consecutive addresses from a configurable base. The host reads the packed hit list after a flush.

## Interface
- BASE_ADDR, 32'h1000_0000, DDR byte address of the first result line
- MIN_LEN, 11, minimum extension length (loc_end - loc_start + 1) kept
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- res_valid  in  1  result present on loc_start/loc_end/score
- loc_start  in  32  extension start location
- loc_end  in  32  extension end location
- score  in  11  extension score
- res_ready  out  1  block can accept a result this cycle
- flush  in  1  one-cycle request: write out partial line
- flush_done  out  1  one-cycle pulse: all accepted records are in DDR
- ddr_wr  out  1  one-cycle write request
- ddr_wr_addr  out  32  line address, held from ddr_wr until ddr_wr_done
- ddr_wr_data  out  512  line data, held from ddr_wr until ddr_wr_done
- ddr_wr_done  in  1  DDR write complete
- rec_count  out  16  records written into lines, saturating at 16'hFFFF

## Operation
- A result is accepted in any cycle with res_valid & res_ready.
- Filtering is applied to the accepted inputs in the acceptance cycle. A result is dropped when any of these holds:
  - loc_end < loc_start (unsigned compare);
  - len = loc_end - loc_start + 1 < MIN_LEN;
  - loc_start and loc_end both equal the last kept record's values. The duplicate register is cleared by reset only.
- Dropped results consume the handshake and change nothing else.
- Record format is {score[10:0], len_sat[20:0], loc_start[31:0]}.
  - len_sat is len saturated to 21'h1FFFFF.
  - Slot i occupies ddr_wr_data[64i+63:64i]; the first kept record goes to slot 0.
- Pack buffer: 8 slots plus pack_cnt (0..8). A kept record goes to slot pack_cnt, then pack_cnt increments and rec_count increments (saturating).
- Line register (line_valid): when pack_cnt==8 and !line_valid, the pack contents move to the line register, pack_cnt returns to 0 and line_valid is set.
- res_ready = rst & (pack_cnt<8) & !flush_pend.
- Write FSM:
  - IDLE: when line_valid, drive ddr_wr=1 for one cycle with addr/data, then go to WAIT.
  - WAIT: hold addr/data. On ddr_wr_done, clear line_valid, add 64 to the address pointer and go to IDLE.
  - The address pointer wraps modulo 2^32.
- Flush:
  - flush sets flush_pend.
  - While flush_pend, if 0 < pack_cnt < 8 and !line_valid, the pack moves to the line register with unused slots zero-filled, and pack_cnt returns to 0.
  - flush_done pulses for one cycle when flush_pend, pack_cnt==0, !line_valid and the FSM is in IDLE; flush_pend clears in the same cycle.
  - A flush with nothing buffered produces flush_done the next cycle and no write.
- If a result is accepted in the same cycle as flush, the record is kept first and the flush includes it.
- A flush arriving while flush_pend is set is absorbed.
- ddr_wr_done outside WAIT is ignored.
- Reset values: res_ready=0 during reset and 1 the cycle after; flush_done=0; ddr_wr=0; ddr_wr_addr=BASE_ADDR; ddr_wr_data=0; rec_count=0.
  - Reset also clears pack_cnt, line_valid, flush_pend and the duplicate register, and returns the FSM to IDLE.
  - Reset mid-write abandons the line; the next write goes to BASE_ADDR.

## Timing
- Accept to slot written: 1 cycle (register at the acceptance edge).
- The 8th accept at edge N: pack_cnt=8 after N. If the line is free, the transfer happens at N+1 and ddr_wr is high in the cycle after N+1.
- res_ready is low for at least one cycle after the 8th accept.
- ddr_wr is high for exactly one cycle per line; the next line's ddr_wr comes no earlier than the cycle after the previous ddr_wr_done.
- Minimum line period: 3 cycles plus DDR latency.
- flush_done arrives no earlier than the cycle after the final ddr_wr_done.

## Test plan
- Reset release then 8 results (start=100k, end=100k+19, score=k): one write at 32'h1000_0000, slot 0 = {11'd0,21'd20,32'd0}, rec_count=8.
- Feed end<start, len=10, and an exact repeat of the previous kept result: all three dropped, rec_count unchanged, no write.
- 3 kept results, then flush: one write with slots 3..7 zero and flush_done one cycle after ddr_wr_done. A second flush with nothing buffered gives flush_done after 1 cycle and no write.
- 20 results with ddr_wr_done delayed 30 cycles: res_ready drops while the pack and line are both full; addresses go BASE, BASE+64, BASE+128 after flush; no records lost.
- Accept in the same cycle as flush: that record appears in the flushed line; a second flush during flush_pend produces no extra flush_done.
- Assert rst (low) while in WAIT: ddr_wr=0, ddr_wr_addr=BASE_ADDR, rec_count=0; the subsequent full line is written to BASE_ADDR.
